// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor holding msip/mtime/mtimecmp behind an LSU port, driving mip and the timer irq.
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [63:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wmask,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic        o_resp_err,
    input  logic        i_csr_clint_mstatus_mie,
    input  logic        i_csr_clint_mie_mtie,
    output logic [63:0] o_csr_clint_mip,
    output logic        o_irq_timer
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t      state, state_nxt;
    logic [63:0] mtime, mtimecmp, bmask, rdata_sel, resp_rdata;
    logic [15:0] presc;
    logic        msip, resp_err, irq, accept, wr, tick, hit_msip, hit_cmp, hit_time, hit;
    for (genvar b = 0; b < 8; b++) begin : g_mask
        assign bmask[b*8 +: 8] = {8{i_req_wmask[b]}};
    end
    assign hit_msip  = i_req_addr == BASE_ADDR;
    assign hit_cmp   = i_req_addr == BASE_ADDR + 64'h4000;
    assign hit_time  = i_req_addr == BASE_ADDR + 64'hBFF8;
    assign hit       = hit_msip | hit_cmp | hit_time;
    assign accept    = i_req_valid & (state == IDLE);
    assign wr        = accept & i_req_wen;
    assign tick      = presc == 16'(TICK_DIV - 1);
    assign rdata_sel = hit_msip ? {63'b0, msip} : hit_cmp ? mtimecmp : hit_time ? mtime : 64'b0;
    assign o_csr_clint_mip = {56'b0, mtime >= mtimecmp, 3'b0, msip, 3'b0};
    assign o_resp_rdata    = resp_rdata;
    assign o_resp_err      = resp_err;
    assign o_irq_timer     = irq;
    always_comb begin
        state_nxt    = (state == IDLE) ? (i_req_valid ? RESP : IDLE) : (i_resp_ready ? IDLE : RESP);
        o_req_ready  = state == IDLE;
        o_resp_valid = state == RESP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mtime      <= '0;
            mtimecmp   <= '1;
            msip       <= 1'b0;
            presc      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state <= state_nxt;
            presc <= tick ? 16'd0 : presc + 16'd1;
            mtime <= (wr & hit_time) ? (mtime & ~bmask) | (i_req_wdata & bmask) : tick ? mtime + 64'd1 : mtime;
            if (wr & hit_cmp) mtimecmp <= (mtimecmp & ~bmask) | (i_req_wdata & bmask);
            if (wr & hit_msip & i_req_wmask[0]) msip <= i_req_wdata[0];
            if (accept) begin
                resp_rdata <= i_req_wen ? 64'b0 : rdata_sel;
                resp_err   <= ~hit;
            end
            irq <= o_csr_clint_mip[7] & i_csr_clint_mstatus_mie & i_csr_clint_mie_mtie;
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed checks of the CLINT timer with TICK_DIV=1 and TICK_DIV=4 instances.
module tb_clint_timer;
    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP = BASE, A_CMP = BASE + 64'h4000, A_TIME = BASE + 64'hBFF8;
    logic        clk = 0, rst = 1, valid1 = 0, valid4 = 0, wen = 0, resp_ready = 1, mie = 0, mtie = 0;
    logic [63:0] addr = 0, wdata = 0;
    logic [7:0]  wmask = 0;
    logic        ready1, rvalid1, err1, irq1, ready4, rvalid4, err4, irq4;
    logic [63:0] rdata1, mip1, rdata4, mip4;
    logic [63:0] rd, mip_mid, hold;
    logic        er, irq_mid;
    int          checks = 0, passes = 0;
    always #5 clk = ~clk;
    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .i_req_valid(valid1), .o_req_ready(ready1), .i_req_addr(addr),
        .i_req_wen(wen), .i_req_wdata(wdata), .i_req_wmask(wmask), .o_resp_valid(rvalid1),
        .i_resp_ready(resp_ready), .o_resp_rdata(rdata1), .o_resp_err(err1),
        .i_csr_clint_mstatus_mie(mie), .i_csr_clint_mie_mtie(mtie), .o_csr_clint_mip(mip1), .o_irq_timer(irq1));
    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .i_req_valid(valid4), .o_req_ready(ready4), .i_req_addr(addr),
        .i_req_wen(wen), .i_req_wdata(wdata), .i_req_wmask(wmask), .o_resp_valid(rvalid4),
        .i_resp_ready(resp_ready), .o_resp_rdata(rdata4), .o_resp_err(err4),
        .i_csr_clint_mstatus_mie(mie), .i_csr_clint_mie_mtie(mtie), .o_csr_clint_mip(mip4), .o_irq_timer(irq4));
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
    task automatic bus(input logic sel4, input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
        check("req_ready_before", sel4 ? ready4 : ready1, 1);
        {valid1, valid4} = sel4 ? 2'b01 : 2'b10;
        addr = a; wen = w; wdata = d; wmask = m;
        @(negedge clk);
        {valid1, valid4} = 2'b00; wen = 0;
        check("resp_valid", sel4 ? rvalid4 : rvalid1, 1);
        rd = sel4 ? rdata4 : rdata1;
        er = sel4 ? err4 : err1;
        mip_mid = mip1;
        irq_mid = irq1;
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask
    initial begin
        do_reset();
        check("rst_req_ready", ready1, 1);
        check("rst_resp_valid", rvalid1, 0);
        check("rst_rdata", rdata1, 0);
        check("rst_err", err1, 0);
        check("rst_mip", mip1, 0);
        check("rst_irq", irq1, 0);
        repeat (5) @(negedge clk);
        check("idle_mip", mip1, 0);
        check("idle_irq", irq1, 0);
        bus(0, A_TIME, 0, 0, 0);
        check("mtime_div1", rd, 5);
        check("mtime_div1_err", er, 0);
        do_reset();
        repeat (12) @(negedge clk);
        bus(1, A_TIME, 0, 0, 0);
        check("mtime_div4", rd, 3);
        // Timer compare: mtime equals the number of edges since release.
        mie = 1; mtie = 1;
        do_reset();
        bus(0, A_CMP, 1, 64'd10, 8'hFF);
        check("write_rdata_zero", rd, 0);
        repeat (7) @(negedge clk);
        check("mtip_before", mip1[7], 0);
        @(negedge clk);
        check("mtip_at_10", mip1, 64'h80);
        check("irq_not_yet", irq1, 0);
        @(negedge clk);
        check("irq_raised", irq1, 1);
        bus(0, A_CMP, 1, '1, 8'hFF);
        check("mtip_cleared", mip_mid[7], 0);
        check("irq_lag", irq_mid, 1);
        check("irq_cleared", irq1, 0);
        bus(0, A_MSIP, 1, 64'd1, 8'h01);
        check("msip_set", mip1, 64'h8);
        bus(0, A_MSIP, 1, 64'd0, 8'h00);
        check("msip_nomask", mip1, 64'h8);
        bus(0, A_MSIP, 0, 0, 0);
        check("msip_read", rd, 1);
        bus(0, A_MSIP, 1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        check("msip_clear", mip1, 0);
        bus(0, A_CMP, 1, 64'h1234_5678_0000_0020, 8'h0F);
        bus(0, A_CMP, 0, 0, 0);
        check("cmp_partial", rd, 64'hFFFF_FFFF_0000_0020);
        bus(0, BASE + 64'h8, 0, 0, 0);
        check("unmapped_err", er, 1);
        check("unmapped_rdata", rd, 0);
        bus(0, A_CMP + 64'h4, 1, 0, 8'hFF);
        check("misaligned_err", er, 1);
        bus(0, A_CMP, 0, 0, 0);
        check("misaligned_ignored", rd, 64'hFFFF_FFFF_0000_0020);
        resp_ready = 0;
        valid1 = 1; addr = A_CMP;
        @(negedge clk);
        valid1 = 0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", rvalid1, 1);
            check("stall_rdata", rdata1, 64'hFFFF_FFFF_0000_0020);
            check("stall_ready", ready1, 0);
            @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        check("stall_release", rvalid1, 0);
        check("stall_ready_back", ready1, 1);
        mtie = 0;
        bus(0, A_CMP, 1, 64'd0, 8'hFF);
        repeat (2) @(negedge clk);
        check("mtip_masked_mip", mip1[7], 1);
        check("mtip_masked_irq", irq1, 0);
        bus(0, A_TIME, 0, 0, 0);
        hold = rd;
        bus(0, A_TIME, 0, 0, 0);
        check("mtime_advances", rd, hold + 2);
        resp_ready = 0;
        valid1 = 1; addr = A_TIME;
        @(negedge clk);
        valid1 = 0;
        check("resp_before_rst", rvalid1, 1);
        rst = 1;
        @(negedge clk);
        check("rst_drop_valid", rvalid1, 0);
        check("rst_drop_ready", ready1, 1);
        check("rst_drop_rdata", rdata1, 0);
        rst = 0; resp_ready = 1;
        bus(0, A_TIME, 0, 0, 0);
        check("mtime_after_rst", rd, 0);
        check("mip_after_rst", mip1, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
